// File: rtl/pjon_tx_arbiter.sv
// Packet-granular round-robin arbiter merging several TX AXI-streams onto the
// single PJDL layer-2 send port, with bus-idle wait, inter-packet gap and stall watchdog.
`timescale 1ns/1ps

package pjon_tx_arbiter_pkg;
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } axis_t;

    typedef struct packed {
        axis_t t;
        logic  tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;
endpackage

module pjon_tx_arbiter #(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned GapCycles    = 16,
    parameter int unsigned StallTimeout = 65535,
    parameter type axis_req_t = pjon_tx_arbiter_pkg::axis_req_t,
    parameter type axis_rsp_t = pjon_tx_arbiter_pkg::axis_rsp_t
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  axis_req_t         req_axis_req_i [NumReq],
    output axis_rsp_t         req_axis_rsp_o [NumReq],
    output axis_req_t         l2_axis_req_o,
    input  axis_rsp_t         l2_axis_rsp_i,
    input  logic              l2_busy_i,
    input  logic              enable_i,
    input  logic              clear_i,
    output logic [NumReq-1:0] grant_o,
    output logic              busy_o,
    output logic              stall_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles + 1) : 1;
    localparam int unsigned StlW = (StallTimeout > 1) ? $clog2(StallTimeout + 1) : 1;
    localparam int unsigned PadN = 1 << IdxW;

    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        DRAIN,
        GAP
    } state_e;

    state_e            state;
    logic [IdxW-1:0]   rr_ptr;
    logic [IdxW-1:0]   gnt_idx;
    logic [GapW-1:0]   gap_cnt;
    logic [StlW-1:0]   stall_cnt;

    logic [PadN-1:0]   valid_pad;
    logic              sel_found;
    logic [IdxW-1:0]   sel_idx;
    logic              l2_hs;
    logic              gnt_last;
    logic              stall_set;

    always_comb begin
        valid_pad = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            valid_pad[i] = req_axis_req_i[i].tvalid;
        end
    end

    // Search starts at rr_ptr so the most recently served requester is checked last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            int unsigned cand;
            cand = (32'(rr_ptr) + k) % NumReq;
            if (!sel_found && valid_pad[IdxW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        l2_axis_req_o = '0;
        if (state == FORWARD) begin
            l2_axis_req_o = req_axis_req_i[gnt_idx];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_axis_rsp_o[i] = '0;
            if (state == FORWARD && gnt_idx == IdxW'(i)) begin
                req_axis_rsp_o[i].tready = l2_axis_rsp_i.tready;
            end
        end
    end

    assign l2_hs     = (state == FORWARD) && req_axis_req_i[gnt_idx].tvalid && l2_axis_rsp_i.tready;
    assign gnt_last  = req_axis_req_i[gnt_idx].t.last;
    assign stall_set = (state == FORWARD) && !l2_hs && (stall_cnt == StlW'(StallTimeout - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            gap_cnt <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && !l2_busy_i && sel_found) begin
                        gnt_idx <= sel_idx;
                        grant_o <= NumReq'(1) << sel_idx;
                        busy_o  <= 1'b1;
                        state   <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (l2_hs && gnt_last) begin
                        rr_ptr  <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
                        grant_o <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!l2_busy_i) begin
                        gap_cnt <= GapW'(GapCycles);
                        if (GapCycles == 0) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state  <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GapW'(1)) begin
                        gap_cnt <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flag fires once as the counter reaches the limit; a saturated counter does not re-set it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            stall_o   <= 1'b0;
        end else begin
            if (state != FORWARD || l2_hs) begin
                stall_cnt <= '0;
            end else if (stall_cnt != StlW'(StallTimeout)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (stall_set) begin
                stall_o <= 1'b1;
            end else if (clear_i) begin
                stall_o <= 1'b0;
            end
        end
    end

endmodule
